// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder.
// No logic and no state. Nothing here sits on the data path.
// No handshake of its own.
package cla_pkg;

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } op_e;

    function automatic int cla_stages(input int width, input int block);
        return width / block;
    endfunction

endpackage

// File: rtl/cla_block.sv
// Combinational N-bit carry-lookahead group with carry-into-MSB for overflow.
// Latency: 0 cycles. This is purely combinational.
// Backpressure: none. The enclosing pipeline stage registers the outputs.
module cla_block #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         c_msb
);

    logic [N-1:0] w_g;
    logic [N-1:0] w_p;
    logic [N:0]   w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Each carry is a flat sum of products over g/p and cin, so no carry depends on another.
    always_comb begin
        logic acc;
        logic prop;
        acc    = 1'b0;
        prop   = 1'b0;
        w_c    = '0;
        w_c[0] = cin;
        for (int i = 0; i < N; i++) begin
            acc  = w_g[i];
            prop = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc  = acc | (prop & w_g[j]);
                prop = prop & w_p[j];
            end
            acc      = acc | (prop & cin);
            w_c[i+1] = acc;
        end
    end

    assign sum   = w_p ^ w_c[N-1:0];
    assign cout  = w_c[N];
    assign c_msb = w_c[N-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined add/subtract that resolves one BLOCK-bit chunk per stage, with carry, overflow and zero flags.
// Latency: STAGES cycles from accept to out_valid. Throughput is one result per cycle.
// Backpressure: the whole pipe holds when out_valid & !out_ready, and in_ready drops in the same cycle.
module pipelined_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    input  op_e              OP,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int STAGES = cla_stages(WIDTH, BLOCK);

    if (BLOCK < 1 || (WIDTH % BLOCK) != 0) begin : g_bad_cfg
        $error("pipelined_cla_adder: WIDTH must be a non-zero multiple of BLOCK");
    end

    logic w_adv;
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    // Stage 0 works directly on the ports. B is inverted and the carry forced to 1 for SUB.
    logic [WIDTH-1:0] w0_b;
    logic             w0_cin;
    logic [BLOCK-1:0] w0_s;
    logic             w0_co;
    logic             w0_cm;

    assign w0_b   = (OP == SUB) ? ~B : B;
    assign w0_cin = (OP == SUB) ? 1'b1 : CIN;

    cla_block #(.N(BLOCK)) u_blk0 (
        .a     (A[BLOCK-1:0]),
        .b     (w0_b[BLOCK-1:0]),
        .cin   (w0_cin),
        .sum   (w0_s),
        .cout  (w0_co),
        .c_msb (w0_cm)
    );

    logic [WIDTH-1:0] w_l_sum;
    logic             w_l_co;
    logic             w_l_cm;
    logic             w_l_v;

    if (STAGES == 1) begin : g_one
        assign w_l_sum = w0_s;
        assign w_l_co  = w0_co;
        assign w_l_cm  = w0_cm;
        assign w_l_v   = in_valid;
    end else begin : g_multi
        // Stage k holds the unresolved upper operand bits, the resolved low sum and the carry out of chunk k-1.
        for (genvar k = 1; k < STAGES; k++) begin : g_stg
            localparam int LO = k * BLOCK;
            localparam int UW = WIDTH - LO;

            logic             r_v;
            logic             r_c;
            logic [UW-1:0]    r_a;
            logic [UW-1:0]    r_b;
            logic [LO-1:0]    r_s;
            logic             w_pv;
            logic             w_pc;
            logic [UW-1:0]    w_pa;
            logic [UW-1:0]    w_pb;
            logic [LO-1:0]    w_ps;
            logic [BLOCK-1:0] w_s;
            logic             w_co;
            logic             w_cm;
            logic [LO+BLOCK-1:0] w_so;

            if (k == 1) begin : g_src
                assign w_pv = in_valid;
                assign w_pc = w0_co;
                assign w_pa = A[WIDTH-1:BLOCK];
                assign w_pb = w0_b[WIDTH-1:BLOCK];
                assign w_ps = w0_s;
            end else begin : g_src
                assign w_pv = g_stg[k-1].r_v;
                assign w_pc = g_stg[k-1].w_co;
                assign w_pa = g_stg[k-1].r_a[UW+BLOCK-1:BLOCK];
                assign w_pb = g_stg[k-1].r_b[UW+BLOCK-1:BLOCK];
                assign w_ps = g_stg[k-1].w_so;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_v <= 1'b0;
                    r_c <= 1'b0;
                    r_a <= '0;
                    r_b <= '0;
                    r_s <= '0;
                end else if (w_adv) begin
                    r_v <= w_pv;
                    if (w_pv) begin
                        r_c <= w_pc;
                        r_a <= w_pa;
                        r_b <= w_pb;
                        r_s <= w_ps;
                    end
                end
            end

            cla_block #(.N(BLOCK)) u_blk (
                .a     (r_a[BLOCK-1:0]),
                .b     (r_b[BLOCK-1:0]),
                .cin   (r_c),
                .sum   (w_s),
                .cout  (w_co),
                .c_msb (w_cm)
            );

            assign w_so = {w_s, r_s};
        end

        assign w_l_sum = g_stg[STAGES-1].w_so;
        assign w_l_co  = g_stg[STAGES-1].w_co;
        assign w_l_cm  = g_stg[STAGES-1].w_cm;
        assign w_l_v   = g_stg[STAGES-1].r_v;
    end

    // Flags are taken from the last chunk's carries and registered together with the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (w_adv) begin
            out_valid <= w_l_v;
            if (w_l_v) begin
                result <= w_l_sum;
                cout   <= w_l_co;
                ovf    <= w_l_co ^ w_l_cm;
                zero   <= ~|w_l_sum;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed and scoreboarded checks of the 32/8 pipelined adder, plus an 8/8 single-stage instance.
module tb_pipelined_cla_adder;
    import cla_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, CIN, out_valid, out_ready, cout, ovf, zero;
    op_e         OP;
    logic [31:0] A, B, result;

    logic        i8_valid, o8_ready, i8_cin, o8_valid, i8_ordy, o8_cout, o8_ovf, o8_zero;
    op_e         i8_op;
    logic [7:0]  i8_a, i8_b, o8_result;

    pipelined_cla_adder #(.WIDTH(32), .BLOCK(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .CIN(CIN), .OP(OP), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout), .ovf(ovf), .zero(zero)
    );

    pipelined_cla_adder #(.WIDTH(8), .BLOCK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(i8_valid), .in_ready(o8_ready),
        .A(i8_a), .B(i8_b), .CIN(i8_cin), .OP(i8_op), .out_valid(o8_valid), .out_ready(i8_ordy),
        .result(o8_result), .cout(o8_cout), .ovf(o8_ovf), .zero(o8_zero)
    );

    typedef struct {
        logic [31:0] res;
        logic        co;
        logic        ov;
        logic        z;
    } exp_t;

    typedef struct {
        op_e         op;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        exp_t        e;
    } vec_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   n_out = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input op_e op, input logic [31:0] a, input logic [31:0] b, input logic cin,
                                 input logic [31:0] res, input logic co, input logic ov, input logic z);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.cin = cin;
        v.e.res = res; v.e.co = co; v.e.ov = ov; v.e.z = z;
        return v;
    endfunction

    // Reference: 33-bit addition, with overflow from operand and result sign bits.
    function automatic exp_t model(input op_e op, input logic [31:0] a, input logic [31:0] b, input logic cin);
        exp_t        e;
        logic [31:0] bb;
        logic        c0;
        bb = (op == SUB) ? ~b : b;
        c0 = (op == SUB) ? 1'b1 : cin;
        {e.co, e.res} = {1'b0, a} + {1'b0, bb} + {32'd0, c0};
        e.ov = (a[31] == bb[31]) && (e.res[31] != a[31]);
        e.z  = (e.res == 32'd0);
        return e;
    endfunction

    // One cycle: drive, decide handshakes before the edge, score any output, end on the next negedge.
    task automatic step(input logic iv, input op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic ordy, output logic acc, output logic popped);
        in_valid  = iv;
        OP        = op;
        A         = a;
        B         = b;
        CIN       = cin;
        out_ready = ordy;
        #1;
        acc    = in_valid && in_ready;
        popped = out_valid && out_ready;
        if (popped) begin
            n_out++;
            if (q.size() == 0) begin
                chk1("out_valid_unexpected", out_valid, 1'b0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", result, e.res);
                chk1("cout", cout, e.co);
                chk1("ovf", ovf, e.ov);
                chk1("zero", zero, e.z);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[12];
        logic        acc, pop;
        int          lat, sent, gaps, cyc;
        logic        started;
        logic [31:0] ra, rb, snap_r;
        logic        rc;
        op_e         rop;
        logic [2:0]  snap_f;
        exp_t        bp_e[6];

        vt[0]  = mkv(ADD, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        vt[1]  = mkv(SUB, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        vt[2]  = mkv(ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        vt[3]  = mkv(SUB, 32'h0000_0005, 32'h0000_0005, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        vt[4]  = mkv(SUB, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        vt[5]  = mkv(ADD, 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b0, 1'b0);
        vt[6]  = mkv(ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        vt[7]  = mkv(ADD, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
        vt[8]  = mkv(SUB, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        vt[9]  = mkv(ADD, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
        vt[10] = mkv(SUB, 32'h0000_0010, 32'h0000_0003, 1'b1, 32'h0000_000D, 1'b1, 1'b0, 1'b0);
        vt[11] = mkv(ADD, 32'h00FF_FFFF, 32'h0000_0000, 1'b1, 32'h0100_0000, 1'b0, 1'b0, 1'b0);

        rst_n = 1'b0; in_valid = 1'b0; OP = ADD; A = '0; B = '0; CIN = 1'b0; out_ready = 1'b1;
        i8_valid = 1'b0; i8_op = ADD; i8_a = '0; i8_b = '0; i8_cin = 1'b0; i8_ordy = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk1("reset_out_valid", out_valid, 1'b0);
        chk1("reset_in_ready", in_ready, 1'b1);
        chk("reset_result", result, 32'd0);
        chk("reset_flags", {29'd0, cout, ovf, zero}, 32'd0);
        chk1("reset8_out_valid", o8_valid, 1'b0);

        // Directed table, one transaction at a time, with latency measured to the output handshake.
        for (int i = 0; i < 12; i++) begin
            step(1'b1, vt[i].op, vt[i].a, vt[i].b, vt[i].cin, 1'b1, acc, pop);
            chk1("tbl_accept", acc, 1'b1);
            if (acc) q.push_back(vt[i].e);
            lat = 0;
            pop = 1'b0;
            while (!pop && lat < 10) begin
                step(1'b0, ADD, 32'd0, 32'd0, 1'b0, 1'b1, acc, pop);
                lat++;
            end
            chk("tbl_latency", lat, 32'd4);
        end

        // Back-to-back random mixed ADD/SUB stream.
        n_out = 0; sent = 0; gaps = 0; cyc = 0; started = 1'b0;
        while ((sent < 100 || q.size() > 0) && cyc < 300) begin
            if (sent < 100) begin
                ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
                rop = op_e'($urandom_range(0, 1));
                step(1'b1, rop, ra, rb, rc, 1'b1, acc, pop);
                if (acc) begin
                    q.push_back(model(rop, ra, rb, rc));
                    sent++;
                end
            end else begin
                step(1'b0, ADD, 32'd0, 32'd0, 1'b0, 1'b1, acc, pop);
            end
            if (pop) started = 1'b1;
            else if (started && n_out < 100) gaps++;
            cyc++;
        end
        chk("stream_outputs", n_out, 32'd100);
        chk("stream_gaps", gaps, 32'd0);
        chk("stream_pending", q.size(), 32'd0);

        // Backpressure: fill with out_ready low, hold 5 cycles, then drain.
        for (int i = 0; i < 6; i++) bp_e[i] = model(ADD, 32'h1000_0000 * i, 32'h0000_0101 * i, 1'b1);
        n_out = 0; sent = 0;
        for (int c = 0; c < 8; c++) begin
            step(1'b1, ADD, 32'h1000_0000 * sent, 32'h0000_0101 * sent, 1'b1, 1'b0, acc, pop);
            if (acc) begin
                q.push_back(bp_e[sent]);
                sent++;
            end
        end
        chk("bp_accepted", sent, 32'd4);
        chk1("bp_in_ready", in_ready, 1'b0);
        snap_r = result;
        snap_f = {cout, ovf, zero};
        for (int c = 0; c < 5; c++) begin
            step(1'b1, ADD, 32'h1000_0000 * sent, 32'h0000_0101 * sent, 1'b1, 1'b0, acc, pop);
            chk1("bp_no_accept", acc, 1'b0);
            chk("bp_result_stable", result, snap_r);
            chk("bp_flags_stable", {29'd0, cout, ovf, zero}, {29'd0, snap_f});
        end
        cyc = 0;
        while ((sent < 6 || q.size() > 0) && cyc < 40) begin
            step(sent < 6, ADD, 32'h1000_0000 * sent, 32'h0000_0101 * sent, 1'b1, 1'b1, acc, pop);
            if (acc) begin
                q.push_back(bp_e[sent]);
                sent++;
            end
            cyc++;
        end
        chk("bp_outputs", n_out, 32'd6);
        chk("bp_pending", q.size(), 32'd0);

        // Reset with one result at the output and three transactions behind it.
        n_out = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, SUB, 32'd100 + i, 32'd1, 1'b0, 1'b1, acc, pop);
            if (acc) q.push_back(model(SUB, 32'd100 + i, 32'd1, 1'b0));
        end
        chk1("rst_pre_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("rst_async_valid", out_valid, 1'b0);
        chk("rst_async_result", result, 32'd0);
        q.delete();
        n_out = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b0, ADD, 32'd0, 32'd0, 1'b0, 1'b1, acc, pop);
        chk("rst_outputs", n_out, 32'd0);

        // Single-stage instance: 1-cycle latency.
        chk1("w8_in_ready", o8_ready, 1'b1);
        i8_valid = 1'b1; i8_op = ADD; i8_a = 8'hFF; i8_b = 8'h00; i8_cin = 1'b1;
        @(negedge clk);
        i8_valid = 1'b0;
        chk1("w8_add_valid", o8_valid, 1'b1);
        chk("w8_add_result", {24'd0, o8_result}, 32'h0000_0000);
        chk1("w8_add_cout", o8_cout, 1'b1);
        chk1("w8_add_zero", o8_zero, 1'b1);
        chk1("w8_add_ovf", o8_ovf, 1'b0);
        @(negedge clk);
        chk1("w8_bubble_valid", o8_valid, 1'b0);
        i8_valid = 1'b1; i8_op = SUB; i8_a = 8'h80; i8_b = 8'h01; i8_cin = 1'b0;
        @(negedge clk);
        i8_valid = 1'b0;
        chk1("w8_sub_valid", o8_valid, 1'b1);
        chk("w8_sub_result", {24'd0, o8_result}, 32'h0000_007F);
        chk1("w8_sub_cout", o8_cout, 1'b1);
        chk1("w8_sub_ovf", o8_ovf, 1'b1);
        chk1("w8_sub_zero", o8_zero, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
